axis_command_encoder: RTL and testbench



---
 rtl/axis_command_encoder_pkg.sv | 40 ++++
 rtl/axis_command_encoder_run_splitter.sv | 48 ++++
 rtl/axis_command_encoder.sv | 121 ++++++++++++
 tb/tb_axis_command_encoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_command_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : encoder_config (package)
// Description : Shared opcode/state types and word-layout helpers for the
//               AXI-Stream command encoder.
// Revision    : 1.0 - initial release
// ============================================================================

// Round a bit width up to the next whole byte.
`define WIDTH_NEAREST_BYTE(w) ((((w) + 7) / 8) * 8)

package encoder_config;

    localparam int OPC_WIDTH = 2;

    typedef enum logic [OPC_WIDTH-1:0] {
        OP_NOP = 2'd0,
        OP_RUN = 2'd1,
        OP_SPK = 2'd2,
        OP_CLR = 2'd3
    } opcode_t;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_RUN_SPLIT = 1'b1
    } state_t;

    // The spike charge sits in its own byte lane at the bottom of the word,
    // the input index starts at the next byte boundary.
    function automatic int chg_lane_width(input int chg_width);
        return `WIDTH_NEAREST_BYTE(chg_width);
    endfunction

    function automatic int spk_field_width(input int idx_width, input int chg_width);
        return chg_lane_width(chg_width) + idx_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_command_encoder_run_splitter.sv
`default_nettype none
// ============================================================================
// Module      : run_splitter
// Description : Breaks a long RUN length into per-word counts of at most
//               2^RUN_WIDTH-1, holding the unsent remainder between words.
// Revision    : 1.0 - initial release
// ============================================================================
module run_splitter
    import encoder_config::*;
#(
    parameter int RUN_WIDTH = 14,
    parameter int LEN_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 load,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 advance,
    output logic [RUN_WIDTH-1:0] count,
    output logic                 last
);

    localparam logic [LEN_WIDTH-1:0] c_run_max = LEN_WIDTH'({RUN_WIDTH{1'b1}});

    logic [LEN_WIDTH-1:0] r_remaining;
    logic [LEN_WIDTH-1:0] w_src;
    logic                 w_gt_max;

    // A fresh load works on the new length, otherwise on what is left over.
    always_comb begin
        w_src    = load ? len : r_remaining;
        w_gt_max = (w_src > c_run_max);
        count    = w_gt_max ? c_run_max[RUN_WIDTH-1:0] : w_src[RUN_WIDTH-1:0];
        last     = !w_gt_max;
    end

    // Remainder register; the subtraction only happens behind the > MAX test.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_remaining <= '0;
        end else if (load || advance) begin
            r_remaining <= w_gt_max ? (w_src - c_run_max) : '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axis_command_encoder.sv
`default_nettype none
// ============================================================================
// Module      : axis_command_encoder
// Description : Turns valid/ready network commands (SPK/RUN/CLR/NOP) into
//               opcode-tagged AXI-Stream words, splitting long RUNs.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_command_encoder
    import encoder_config::*;
#(
    parameter int IDX_WIDTH   = 4,
    parameter int CHG_WIDTH   = 8,
    parameter int TDATA_WIDTH = 16,
    parameter int RUN_WIDTH   = TDATA_WIDTH - OPC_WIDTH,
    parameter int LEN_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [OPC_WIDTH-1:0]   cmd_op,
    input  logic [IDX_WIDTH-1:0]   cmd_idx,
    input  logic [CHG_WIDTH-1:0]   cmd_chg,
    input  logic [LEN_WIDTH-1:0]   cmd_len,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   busy
);

    localparam int c_chg_lane = chg_lane_width(CHG_WIDTH);

    state_t                 r_state;
    logic [TDATA_WIDTH-1:0] r_tdata;
    logic                   r_tvalid;

    opcode_t                w_cmd_op;
    logic                   w_slot_free;
    logic                   w_accept;
    logic                   w_run_load;
    logic                   w_run_adv;
    logic [RUN_WIDTH-1:0]   w_count;
    logic                   w_last;
    logic [RUN_WIDTH-1:0]   w_spk_payload;
    logic                   w_load_word;
    logic [TDATA_WIDTH-1:0] w_word;

    assign w_cmd_op    = opcode_t'(cmd_op);
    assign w_slot_free = !r_tvalid || m_axis_tready;
    assign cmd_ready   = (r_state == ST_IDLE) && w_slot_free && !arst;
    assign w_accept    = cmd_valid && cmd_ready;
    // A zero-length RUN is consumed without producing a word.
    assign w_run_load  = w_accept && (w_cmd_op == OP_RUN) && (cmd_len != '0);
    assign w_run_adv   = (r_state == ST_RUN_SPLIT) && w_slot_free;

    run_splitter #(
        .RUN_WIDTH (RUN_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_run_splitter (
        .clk     (clk),
        .arst    (arst),
        .load    (w_run_load),
        .len     (cmd_len),
        .advance (w_run_adv),
        .count   (w_count),
        .last    (w_last)
    );

    // Build the next output word: charge in the low byte lane, index above.
    always_comb begin
        w_spk_payload                           = '0;
        w_spk_payload[CHG_WIDTH-1:0]            = cmd_chg;
        w_spk_payload[c_chg_lane +: IDX_WIDTH]  = cmd_idx;
        w_load_word = 1'b0;
        w_word      = '0;
        if (w_run_load || w_run_adv) begin
            w_load_word = 1'b1;
            w_word      = {OP_RUN, w_count};
        end else if (w_accept) begin
            case (w_cmd_op)
                OP_SPK: begin
                    w_load_word = 1'b1;
                    w_word      = {OP_SPK, w_spk_payload};
                end
                OP_CLR: begin
                    w_load_word = 1'b1;
                    w_word      = {OP_CLR, {RUN_WIDTH{1'b0}}};
                end
                default: ;
            endcase
        end
    end

    // Output register and split-state control; a load always wins over a drop.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state  <= ST_IDLE;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
        end else begin
            if (w_load_word) begin
                r_tdata  <= w_word;
                r_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
            if (w_run_load && !w_last) begin
                r_state <= ST_RUN_SPLIT;
            end else if (w_run_adv && w_last) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign busy          = (r_state != ST_IDLE) || r_tvalid;

endmodule

`default_nettype wire

// File: tb/tb_axis_command_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_command_encoder
// Description : Scoreboard bench for axis_command_encoder: directed scenarios
//               plus random commands against a behavioural word model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_command_encoder;

    localparam int MAXR = (1 << 14) - 1;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [3:0]  cmd_idx = '0;
    logic [7:0]  cmd_chg = '0;
    logic [31:0] cmd_len = '0;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random
    logic [15:0] exp_q[$];

    axis_command_encoder dut (
        .clk           (clk),
        .arst          (arst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_idx       (cmd_idx),
        .cmd_chg       (cmd_chg),
        .cmd_len       (cmd_len),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: list of words a command must produce, by plain arithmetic.
    task automatic model_push(input logic [1:0] op, input logic [3:0] idx,
                              input logic [7:0] chg, input logic [31:0] len);
        longint rem;
        case (op)
            2'd1: begin
                rem = longint'(len);
                while (rem > MAXR) begin
                    exp_q.push_back(16'(32'h4000 + MAXR));
                    rem -= MAXR;
                end
                if (rem != 0) exp_q.push_back(16'(64'h4000 + rem));
            end
            2'd2: exp_q.push_back(16'(32'h8000 + (int'(idx) << 8) + int'(chg)));
            2'd3: exp_q.push_back(16'hC000);
            default: ;
        endcase
    endtask

    // Offer one command, wait for acceptance, record its expected words.
    task automatic send(input logic [1:0] op, input logic [3:0] idx,
                        input logic [7:0] chg, input logic [31:0] len);
        int n;
        n = 0;
        cmd_op = op; cmd_idx = idx; cmd_chg = chg; cmd_len = len;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (!cmd_ready) chk("cmd_accept_timeout", cmd_ready, 1);
        else model_push(op, idx, chg, len);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // Downstream ready pattern, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = 1'b0;
                default: m_axis_tready = (($urandom % 4) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks stall stability.
    initial begin
        logic        hold;
        logic [15:0] held;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (arst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("stall_tvalid_held", m_axis_tvalid, 1);
                    chk("stall_tdata_held", m_axis_tdata, held);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) chk("unexpected_word_queue_size", exp_q.size(), 1);
                    else chk("word", m_axis_tdata, exp_q.pop_front());
                    hold = 1'b0;
                end else if (m_axis_tvalid) begin
                    hold = 1'b1;
                    held = m_axis_tdata;
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] len;
        int          n;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
        arst = 1'b0;

        // SPK idx=5 chg=-3
        send(2'd2, 4'd5, 8'hFD, 32'd0);
        chk("spk_latency_tvalid", m_axis_tvalid, 1);
        chk("spk_tdata", m_axis_tdata, 16'h85FD);
        next_cycle();
        chk("spk_busy_low", busy, 0);

        // Short RUN
        send(2'd1, 4'd0, 8'd0, 32'd3);
        chk("run3_tdata", m_axis_tdata, 16'h4003);
        next_cycle();

        // Long RUN, split into three back-to-back words
        send(2'd1, 4'd0, 8'd0, 32'd40000);
        chk("run_split_w0", m_axis_tdata, 16'h7FFF);
        @(negedge clk);
        chk("run_split_ready_low0", cmd_ready, 0);
        next_cycle();
        chk("run_split_w1", m_axis_tdata, 16'h7FFF);
        @(negedge clk);
        chk("run_split_ready_low1", cmd_ready, 0);
        next_cycle();
        chk("run_split_w2_valid", m_axis_tvalid, 1);
        chk("run_split_w2", m_axis_tdata, 16'h5C42);
        @(negedge clk);
        chk("run_split_ready_back", cmd_ready, 1);
        next_cycle();

        // Commands that emit nothing
        send(2'd1, 4'd0, 8'd0, 32'd0);
        chk("run0_no_tvalid", m_axis_tvalid, 0);
        chk("run0_ready", cmd_ready, 1);
        send(2'd0, 4'd7, 8'd7, 32'd9);
        chk("nop_no_tvalid", m_axis_tvalid, 0);
        next_cycle();
        chk("nop_no_tvalid_later", m_axis_tvalid, 0);
        chk("nop_ready", cmd_ready, 1);

        // CLR under back-pressure
        rdy_mode = 1;
        next_cycle();
        send(2'd3, 4'd0, 8'd0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("clr_stall_tvalid", m_axis_tvalid, 1);
            chk("clr_stall_tdata", m_axis_tdata, 16'hC000);
            next_cycle();
        end
        rdy_mode = 0;
        repeat (3) next_cycle();
        chk("clr_drained_queue", exp_q.size(), 0);

        // Reset during the second word of a split RUN
        send(2'd1, 4'd0, 8'd0, 32'd40000);
        @(posedge clk); #2;
        arst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_tvalid", m_axis_tvalid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
        arst = 1'b0;
        @(negedge clk);
        chk("postrst_first_ready", cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postrst_no_resume", m_axis_tvalid, 0);
        end
        next_cycle();
        send(2'd2, 4'd10, 8'h7F, 32'd0);
        chk("postrst_spk", m_axis_tdata, 16'h8A7F);
        next_cycle();

        // Back-to-back single-word commands at full rate
        send(2'd2, 4'd1, 8'h80, 32'd0);
        send(2'd3, 4'd0, 8'd0, 32'd0);
        chk("b2b_clr", m_axis_tdata, 16'hC000);
        send(2'd1, 4'd0, 8'd0, 32'd1);
        chk("b2b_run1", m_axis_tdata, 16'h4001);

        // Random commands with random back-pressure
        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom % 4);
            case ($urandom % 8)
                0: len = 32'd0;
                1: len = MAXR;
                2: len = MAXR + 1;
                3: len = 2 * MAXR;
                4: len = 2 * MAXR + 1;
                5: len = $urandom % 16;
                default: len = $urandom % (4 * MAXR);
            endcase
            send(op, 4'($urandom), 8'($urandom), len);
            repeat ($urandom % 3) next_cycle();
        end

        // Drain
        rdy_mode = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        repeat (2) next_cycle();
        chk("final_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
